// File: rtl/display_pkg.sv
// Shared types and default geometry for the display adapter's ping-pong pixel buffers.
package display_pkg;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} buf_state_t;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_ADDR_W = 10;
endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Host write stream, display read strobes and the two buffer RAM control ports.
interface frame_buffer_arbiter_if import display_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
    logic              wr_valid;
    logic              wr_ready;
    logic              frame_start;
    logic              rd_en;
    logic              we0, we1;
    logic              re0, re1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              wr_sel;
    logic              rd_sel;
    logic              rd_valid;
    logic              buf0_full, buf1_full;
    logic              frame_repeat;
    logic              underrun;

    modport master (
        output wr_valid, frame_start, rd_en,
        input  wr_ready, we0, we1, re0, re1, addr0, addr1, wr_sel, rd_sel,
               rd_valid, buf0_full, buf1_full, frame_repeat, underrun
    );
    modport slave (
        input  wr_valid, frame_start, rd_en,
        output wr_ready, we0, we1, re0, re1, addr0, addr1, wr_sel, rd_sel,
               rd_valid, buf0_full, buf1_full, frame_repeat, underrun
    );
endinterface

// File: rtl/pingpong_buf_state.sv
// Lifecycle of one pixel buffer: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
module pingpong_buf_state import display_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_wr,
    input  logic       accept,
    input  logic       last,
    input  logic       swap,
    output buf_state_t state,
    output logic       full
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            full  <= 1'b0;
        end else if (swap) begin
            // Write target is promoted to display; the displayed buffer is recycled.
            state <= is_wr ? READING : EMPTY;
            full  <= is_wr;
        end else if (is_wr && accept) begin
            state <= last ? FULL : FILLING;
            if (last)
                full <= 1'b1;
        end
    end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Ping-pong scheduler: host fills one buffer while the display reads the other; roles swap at frame start.
module frame_buffer_arbiter import display_pkg::*; #(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    frame_buffer_arbiter_if.slave   bus
);
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_sel;
    logic              frame_repeat, underrun;
    buf_state_t        st0, st1, wr_state, rd_state;
    logic              full0, full1;
    logic              wr_ready, accept, wr_last, rd_last, do_swap, rd_valid, rd_fire;

    assign wr_state = wr_sel ? st1 : st0;
    assign rd_state = wr_sel ? st0 : st1;
    assign wr_ready = (wr_state != FULL);
    assign accept   = bus.wr_valid && wr_ready;
    assign wr_last  = (wr_addr == ADDR_W'(DEPTH - 1));
    assign rd_last  = (rd_addr == ADDR_W'(DEPTH - 1));
    // A frame completed by this very cycle's write still qualifies for the swap.
    assign do_swap  = bus.frame_start && (wr_state == FULL || (accept && wr_last));
    assign rd_valid = (rd_state == READING);
    assign rd_fire  = bus.rd_en && rd_valid && !bus.frame_start;

    pingpong_buf_state u_buf0 (
        .clk(clk), .reset(reset), .is_wr(!wr_sel), .accept(accept),
        .last(wr_last), .swap(do_swap), .state(st0), .full(full0)
    );
    pingpong_buf_state u_buf1 (
        .clk(clk), .reset(reset), .is_wr(wr_sel), .accept(accept),
        .last(wr_last), .swap(do_swap), .state(st1), .full(full1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            wr_sel       <= 1'b0;
            frame_repeat <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_repeat <= bus.frame_start && !do_swap;
            underrun     <= bus.rd_en && !rd_valid && !bus.frame_start;
            if (do_swap) begin
                wr_sel  <= !wr_sel;
                wr_addr <= '0;
            end else if (accept) begin
                wr_addr <= wr_last ? '0 : wr_addr + ADDR_W'(1);
            end
            if (bus.frame_start)
                rd_addr <= '0;
            else if (rd_fire)
                rd_addr <= rd_last ? '0 : rd_addr + ADDR_W'(1);
        end
    end

    // Roles are complementary, so each buffer's address simply follows its role's counter.
    assign bus.addr0        = wr_sel ? rd_addr : wr_addr;
    assign bus.addr1        = wr_sel ? wr_addr : rd_addr;
    assign bus.we0          = !reset && accept && !wr_sel;
    assign bus.we1          = !reset && accept && wr_sel;
    assign bus.re0          = !reset && rd_fire && wr_sel;
    assign bus.re1          = !reset && rd_fire && !wr_sel;
    assign bus.wr_ready     = wr_ready;
    assign bus.wr_sel       = wr_sel;
    assign bus.rd_sel       = !wr_sel;
    assign bus.rd_valid     = rd_valid;
    assign bus.buf0_full    = full0;
    assign bus.buf1_full    = full1;
    assign bus.frame_repeat = frame_repeat;
    assign bus.underrun     = underrun;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed scenarios plus random traffic against a word-count model of the ping-pong buffers.
module tb_frame_buffer_arbiter;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_buffer_arbiter_if #(.ADDR_W(AW)) bus ();
    frame_buffer_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_tot = 0;
    int n_bad = 0;

    // Model: which buffer is written, how many words it holds, which buffers hold a frame.
    int m_wb, m_cnt, m_rptr;
    bit m_full [2];
    bit m_rd_has, m_rep, m_und;

    int cnt_we0, cnt_we1, cnt_und;
    logic s_rd_sel, s_rep;
    logic [AW-1:0] s_addr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wb = 0; m_cnt = 0; m_rptr = 0;
        m_full[0] = 0; m_full[1] = 0;
        m_rd_has = 0; m_rep = 0; m_und = 0;
    endtask

    task automatic step(input logic wv, input logic fs, input logic re);
        bit acc, rfire, swap;
        int rb;
        logic [AW-1:0] ea [2];
        @(negedge clk);
        bus.wr_valid = wv; bus.frame_start = fs; bus.rd_en = re;
        #1;
        rb    = 1 - m_wb;
        acc   = wv && !m_full[m_wb];
        rfire = re && m_rd_has && !fs;
        ea[m_wb] = AW'(m_cnt % DEPTH);
        ea[rb]   = AW'(m_rptr);
        chk("wr_ready", bus.wr_ready, !m_full[m_wb]);
        chk("we0", bus.we0, acc && m_wb == 0);
        chk("we1", bus.we1, acc && m_wb == 1);
        chk("re0", bus.re0, rfire && rb == 0);
        chk("re1", bus.re1, rfire && rb == 1);
        chk("addr0", bus.addr0, ea[0]);
        chk("addr1", bus.addr1, ea[1]);
        chk("wr_sel", bus.wr_sel, m_wb);
        chk("rd_sel", bus.rd_sel, rb);
        chk("rd_valid", bus.rd_valid, m_rd_has);
        chk("buf0_full", bus.buf0_full, m_full[0]);
        chk("buf1_full", bus.buf1_full, m_full[1]);
        chk("frame_repeat", bus.frame_repeat, m_rep);
        chk("underrun", bus.underrun, m_und);
        cnt_we0 += int'(bus.we0);
        cnt_we1 += int'(bus.we1);
        cnt_und += int'(bus.underrun);
        s_rd_sel = bus.rd_sel; s_rep = bus.frame_repeat; s_addr1 = bus.addr1;
        @(posedge clk);
        if (acc) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_full[m_wb] = 1;
        end
        swap  = fs && m_full[m_wb];
        m_rep = fs && !swap;
        m_und = re && !m_rd_has && !fs;
        if (swap) begin
            m_full[rb] = 0;
            m_wb = rb;
            m_cnt = 0;
            m_rd_has = 1;
        end
        if (fs) m_rptr = 0;
        else if (rfire) m_rptr = (m_rptr + 1) % DEPTH;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.wr_valid = 1'b0; bus.frame_start = 1'b0; bus.rd_en = 1'b0;
        #1;
        chk("rst_en", {bus.we0, bus.we1, bus.re0, bus.re1}, 0);
        chk("rst_sel", {bus.wr_sel, bus.rd_sel}, 2'b01);
        chk("rst_ready", bus.wr_ready, 1);
        chk("rst_flags", {bus.rd_valid, bus.buf0_full, bus.buf1_full, bus.frame_repeat, bus.underrun}, 0);
        chk("rst_addr", {bus.addr0, bus.addr1}, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid = 1'b0; bus.frame_start = 1'b0; bus.rd_en = 1'b0;
        model_reset();
        apply_reset();

        // 1: fill Buf0, write side stalls once full
        cnt_we0 = 0; cnt_we1 = 0;
        repeat (10) step(1, 0, 0);
        chk("s1_we0_cnt", cnt_we0, 8);
        chk("s1_we1_cnt", cnt_we1, 0);

        // 2: swap, then read the frame and wrap
        step(0, 1, 0);
        repeat (9) step(0, 0, 1);

        // 3: partial frame in Buf1 -> repeat
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("s3_repeat", s_rep, 1);
        chk("s3_wr_addr", s_addr1, 3);

        // 5: last write lands in the frame_start cycle
        repeat (4) step(1, 0, 1);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("s5_rd_sel", s_rd_sel, 1);
        chk("s5_no_repeat", s_rep, 0);

        // 4: reads with nothing to show
        apply_reset();
        cnt_und = 0;
        repeat (4) step(0, 0, 1);
        step(0, 0, 0);
        chk("s4_underruns", cnt_und, 4);

        // 6: reset mid-fill drops the write enable at once
        apply_reset();
        repeat (5) step(1, 0, 0);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        #1;
        chk("s6_we0_before", bus.we0, 1);
        reset = 1'b1;
        #1;
        chk("s6_we0_reset", bus.we0, 0);
        chk("s6_addr0", bus.addr0, 0);
        chk("s6_sel", {bus.wr_sel, bus.rd_sel}, 2'b01);
        apply_reset();

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0)
                apply_reset();
            else
                step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
